// File: rtl/mac_feeder_pkg.sv
// mac_feeder_pkg: shared types and constants for the mac_feeder slice.
//   state_t   : feeder FSM states (IDLE, RUN, DRAIN, DONE)
//   mac_res_t : one result FIFO entry {data, status, idx, last}
//   A_LSB/B_LSB/OPND_W : operand field positions inside the 64-bit SRAM word
//   IDX_W     : width of the stored pair index (upper bound on ADDR_W)
package mac_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int IDX_W  = 8;
  localparam int OPND_W = 32;
  localparam int A_LSB  = 0;
  localparam int B_LSB  = 32;

  typedef struct packed {
    logic [31:0]      data;
    logic [7:0]       status;
    logic [IDX_W-1:0] idx;
    logic             last;
  } mac_res_t;

endpackage

// File: rtl/mac_res_fifo.sv
// mac_res_fifo: synchronous FIFO of mac_res_t entries.
//   clk, rst_n   : clock, synchronous active-low reset (flushes the FIFO)
//   push, push_data : write request and entry; accepted when not full, or
//                  when full and a pop happens in the same cycle
//   pop          : read request; ignored when empty
//   valid, head  : head entry and its valid flag (head reads as zero when empty)
//   count        : current occupancy, used by the producer for credit checks
module mac_res_fifo
  import mac_feeder_pkg::*;
#(
  parameter int  DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  mac_res_t         push_data,
  input  logic             pop,
  output logic             valid,
  output mac_res_t         head,
  output logic [CNT_W-1:0] count
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);

  mac_res_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign valid   = (count != '0);
  assign do_pop  = pop && valid;
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mac_feeder.sv
// mac_feeder: job-driven operand streamer for the fixed-latency mac pipeline.
// Reads operand pairs from SRAM, issues them to mac, tags each result with
// its pair index and queues it in a backpressured result FIFO.
//   clk, rst_n            : clock, synchronous active-low reset
//   start, base_addr, len : job request (sampled only when idle)
//   busy, done            : job status; done pulses the cycle after the last pop
//   mem_ren, mem_addr, mem_rdata : operand SRAM read port (1-cycle read latency)
//   mac_en, mac_a, mac_b, mac_rnd : operands to mac
//   mac_out, mac_status   : mac result, MAC_LATENCY cycles after mac_en
//   res_valid, res_ready, res_data, res_status, res_idx, res_last : result stream
//   err_flags             : sticky OR of result status for the current job
// Build option: define MAC_FEEDER_ERR_EN to enable err_flags accumulation;
// otherwise err_flags is constant zero.
module mac_feeder
  import mac_feeder_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int MAC_LATENCY = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [63:0]       mem_rdata,
  output logic              mac_en,
  output logic [31:0]       mac_a,
  output logic [31:0]       mac_b,
  output logic [2:0]        mac_rnd,
  input  logic [31:0]       mac_out,
  input  logic [7:0]        mac_status,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic [7:0]        res_status,
  output logic [ADDR_W-1:0] res_idx,
  output logic              res_last,
  output logic [7:0]        err_flags
);

  localparam int               CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]  LEN_ONE   = (ADDR_W + 1)'(1);

  if (FIFO_DEPTH < MAC_LATENCY + 3) begin : g_depth_check
    $error("mac_feeder: FIFO_DEPTH must be at least MAC_LATENCY+3");
  end
  if (MAC_LATENCY < 1) begin : g_lat_check
    $error("mac_feeder: MAC_LATENCY must be at least 1");
  end
  if (ADDR_W > IDX_W) begin : g_idx_check
    $error("mac_feeder: ADDR_W exceeds the stored index width");
  end

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W:0]   len_last;
  logic [ADDR_W:0]   issue_cnt;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic              credit_ok;
  logic              start_acc;

  logic              rd_valid;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] mac_idx;
  logic              tag_v   [MAC_LATENCY];
  logic [ADDR_W-1:0] tag_idx [MAC_LATENCY];

  logic              fifo_push;
  logic              last_pop;
  mac_res_t          push_data;
  mac_res_t          head;

  assign start_acc = (state == IDLE) && start;
  assign len_last  = len_r - LEN_ONE;
  assign mem_addr  = base_r + issue_cnt[ADDR_W-1:0];
  assign mac_rnd   = '0;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Every issued read owns a FIFO slot from issue until its result is
  // written, so a push can never find the FIFO full without a pop.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < DEPTH_LIM;

  always_comb begin
    state_nxt = state;
    mem_ren   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = (len == '0) ? DONE : RUN;
      end
      RUN: begin
        if (credit_ok) begin
          mem_ren = 1'b1;
          if (issue_cnt == len_last) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (last_pop) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      base_r    <= '0;
      len_r     <= '0;
      issue_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        base_r    <= base_addr;
        len_r     <= len;
        issue_cnt <= '0;
      end else if (mem_ren) begin
        issue_cnt <= issue_cnt + LEN_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      unique case ({mem_ren, fifo_push})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Operand stage: read data arrives the cycle after mem_ren and is
  // registered onto mac_a/mac_b; operands hold through bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_idx   <= '0;
      mac_en   <= 1'b0;
      mac_a    <= '0;
      mac_b    <= '0;
      mac_idx  <= '0;
    end else begin
      rd_valid <= mem_ren;
      rd_idx   <= issue_cnt[ADDR_W-1:0];
      mac_en   <= rd_valid;
      if (rd_valid) begin
        mac_a   <= mem_rdata[A_LSB +: OPND_W];
        mac_b   <= mem_rdata[B_LSB +: OPND_W];
        mac_idx <= rd_idx;
      end
    end
  end

  // Tag pipeline starts one stage after mac_en so its tail lines up with
  // the cycle mac_out is valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAC_LATENCY; i++) begin
        tag_v[i]   <= 1'b0;
        tag_idx[i] <= '0;
      end
    end else begin
      tag_v[0]   <= mac_en;
      tag_idx[0] <= mac_idx;
      for (int unsigned i = 1; i < MAC_LATENCY; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  assign fifo_push        = tag_v[MAC_LATENCY-1];
  assign push_data.data   = mac_out;
  assign push_data.status = mac_status;
  assign push_data.idx    = IDX_W'(tag_idx[MAC_LATENCY-1]);
  assign push_data.last   = ({1'b0, tag_idx[MAC_LATENCY-1]} == len_last);

  mac_res_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (res_ready),
    .valid     (res_valid),
    .head      (head),
    .count     (fifo_count)
  );

  assign res_data   = head.data;
  assign res_status = head.status;
  assign res_idx    = head.idx[ADDR_W-1:0];
  assign res_last   = head.last;
  assign last_pop   = res_valid && res_ready && head.last;

`ifdef MAC_FEEDER_ERR_EN
  logic [7:0] err_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_r <= '0;
    end else if (start_acc) begin
      err_r <= '0;
    end else if (fifo_push) begin
      err_r <= err_r | mac_status;
    end
  end

  assign err_flags = err_r;
`else
  assign err_flags = '0;
`endif

endmodule

// File: doc/mac_feeder.md
# mac_feeder

Job-driven operand streamer that drives the `mac` datapath. It reads operand pairs from an operand SRAM, issues them to the fixed-latency `mac` pipeline, and re-associates each result with its index. Results go into a backpressured result FIFO. It sits between the ESEKF sequencer (job start/done) and the matrix-update logic, which consumes results.

## Interface
- `ADDR_W`, 8: operand SRAM address width; also the job length width.
- `MAC_LATENCY`, 2: cycles from a `mac_en`-high cycle to the matching `mac_out` cycle.
- `FIFO_DEPTH`, 8: result FIFO entries. Must be ≥ MAC_LATENCY+3 for full throughput; an elaboration-time check errors if it is smaller.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: job start pulse; sampled only in IDLE.
- `base_addr` in ADDR_W: first operand address; latched on accepted start.
- `len` in ADDR_W+1: number of operand pairs; latched on accepted start.
- `busy` out 1: high while not IDLE.
- `done` out 1: one-cycle pulse when the last result is popped.
- `mem_ren` out 1: SRAM read enable.
- `mem_addr` out ADDR_W: SRAM read address.
- `mem_rdata` in 64: read data, valid the cycle after `mem_ren`. Operand a is [31:0], b is [63:32].
- `mac_en` out 1: operand-valid strobe to `mac`.
- `mac_a`, `mac_b` out 32: fp32 operands.
- `mac_rnd` out 3: rounding mode, constant 3'b000.
- `mac_out` in 32: fp32 result from `mac`.
- `mac_status` in 8: result status flags.
- `res_valid` out 1: FIFO head valid.
- `res_ready` in 1: consumer accept.
- `res_data` out 32: result value.
- `res_status` out 8: result status.
- `res_idx` out ADDR_W: 0-based pair index within the job.
- `res_last` out 1: marks the final result of the job.
- `err_flags` out 8: sticky status OR (see Configuration).

## Operation
- FSM states are IDLE, RUN, DRAIN, DONE.
- **IDLE → RUN** on `start` when `len` ≠ 0. `base_addr`, `len`, issue counter and result counter are all latched/cleared.
- **IDLE → DONE** on `start` when `len` = 0. No reads are issued.
- **RUN:** each cycle, issue one read (`mem_ren`=1, `mem_addr`=base+issue_cnt) only if fifo_count + inflight < FIFO_DEPTH. Inflight counts reads issued whose result has not yet been written to the FIFO.
- **Address wrap:** addresses wrap modulo 2^ADDR_W.
- **RUN → DRAIN** in the cycle the len-th read issues.
- **DRAIN → DONE** when the last result (res_last=1) is popped (`res_valid && res_ready`).
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- **Operand path:**
  - `mem_rdata` is registered into `mac_a`/`mac_b` with `mac_en`=1 for one cycle.
  - `mac_en`=0 on bubble cycles; `mac_a`/`mac_b` hold their last value.
- **Result tagging:**
  - A MAC_LATENCY-deep valid/index shift register runs in parallel with `mac`.
  - Where it emerges valid, {`mac_out`, `mac_status`, idx, idx==len-1} is pushed into the FIFO.
  - Results are never dropped: the credit rule guarantees space.
- `start` while `busy` is ignored.
- **Simultaneous push and pop:** count is unchanged; push and pop in the same cycle on a full FIFO is legal.
- **Reset mid-job:** all state cleared, FIFO flushed, in-flight MAC results discarded.
- **Reset values:** busy=0, done=0, mem_ren=0, mem_addr=0, mac_en=0, mac_a=0, mac_b=0, mac_rnd=0, res_valid=0, res_data/status/idx/last=0, err_flags=0.

## Timing
- Start accepted at cycle s; first `mem_ren` at s+1.
- `mac_en` at s+3 (read at s+1, rdata valid at s+2, registered onto `mac_a`/`mac_b` at the end of s+2).
- Result pushed into the FIFO at the end of cycle s+3+MAC_LATENCY.
- First `res_valid` at s+4+MAC_LATENCY.
- Throughput is one result per cycle with `res_ready` held high.
- With `res_ready` low, issue stalls once credits are exhausted and resumes the cycle after a pop frees a credit.
- `done` is asserted the cycle after the last pop.

## Configuration
- `MAC_FEEDER_ERR_EN` defined:
  - `err_flags` is the bitwise OR of `mac_status` of every result pushed in the current job.
  - It is cleared on an accepted start and held after DONE until the next start.
- `MAC_FEEDER_ERR_EN` undefined: `err_flags` is tied to 0 and the accumulation logic is absent.

## Structure
- `mac_feeder_pkg` holds:
  - the state enum;
  - `mac_res_t` struct {data[31:0], status[7:0], idx, last};
  - the operand field slice constants (A_LSB=0, B_LSB=32).
- Sub-module `mac_res_fifo`: a synchronous FIFO of `mac_res_t` that exposes count for the credit check. Parameterised by depth.

## Test plan
- **Single job:** bench MAC model (fp32 multiply, latency 2), base=0x10, len=4, pairs (3F800000,40000000)…, res_ready=1. Required: results 40000000…, idx 0..3, res_last only on idx 3; first res_valid 6 cycles after start; done one cycle after the last pop.
- **Zero length:** len=0 start. Required: done at start+1, no mem_ren, no res_valid.
- **Backpressure:** len=20, res_ready low for cycles 5–30. Required: FIFO fills to 8 with no overflow; mem_ren stalls; all 20 results arrive in index order.
- **Address wrap:** ADDR_W=8, base=0xFE, len=4. Required: mem_addr sequence FE, FF, 00, 01.
- **Reset mid-job:** rst_n low for one cycle at DRAIN. Required: all outputs at reset values the next cycle; a following job's results carry no stale entries.
- **Error flags (ERR_EN):** model returns status 8'h04 on idx 2 only. Required: err_flags=8'h04 after done, and 8'h00 on the next start.
